// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port 2**ADDR_W x DATA_W memory with a tri-state read port.
// Each command is one read or write burst of req_len+1 beats at consecutive, wrapping addresses.
module mem_burst_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_e,
  output logic              mem_read_e,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_ISSUE, S_RD_HOLD} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_req_ready;
  logic                r_wd_ready;
  logic                r_rd_valid;
  logic                r_done;
  logic                r_read_e;
  logic [DATA_W-1:0]   r_rd_data;
  logic                w_in_wr;

  // Write strobe is combinational so the memory captures the beat on the same edge it is accepted.
  assign w_in_wr     = (r_state == S_WR);
  assign mem_write_e = w_in_wr & wd_valid;
  assign mem_wdata   = w_in_wr ? wd_data : '0;
  assign mem_addr    = r_addr;
  assign mem_read_e  = r_read_e;
  assign req_ready   = r_req_ready;
  assign wd_ready    = r_wd_ready;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign done        = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_wd_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_read_e    <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_addr      <= req_addr;
            r_cnt       <= req_len;
            r_req_ready <= 1'b0;
            if (req_write) begin
              r_state    <= S_WR;
              r_wd_ready <= 1'b1;
            end else begin
              r_state  <= S_RD_ISSUE;
              r_read_e <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (wd_valid) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state     <= S_IDLE;
              r_wd_ready  <= 1'b0;
              r_req_ready <= 1'b1;
              r_done      <= 1'b1;
            end
          end
        end
        // Memory drives its output only during this single read_e cycle.
        S_RD_ISSUE: begin
          r_rd_data  <= mem_rdata;
          r_read_e   <= 1'b0;
          r_rd_valid <= 1'b1;
          r_state    <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            r_rd_valid <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            r_cnt      <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_done      <= 1'b1;
            end else begin
              r_state  <= S_RD_ISSUE;
              r_read_e <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
